// File: rtl/div32x32.sv
// -----------------------------------------------------------------------------
// div32x32 -- iterative 32-bit unsigned restoring divider (radix-2).
// Produces one quotient bit per clock with a fixed 32-cycle latency.
// Companion to mult32x32 and uses the same start/busy handshake.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   start        in   1   request a division (sampled only while idle)
//   a            in  32   dividend, unsigned
//   b            in  32   divisor, unsigned
//   busy         out  1   high while a division is in progress
//   quotient     out 32   floor(a/b), held until the next accepted start
//   remainder    out 32   a mod b, held until the next accepted start
//   div_by_zero  out  1   last accepted division had b == 0
// -----------------------------------------------------------------------------
module div32x32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t      state_q;
  logic [31:0] d_q;       // latched divisor
  logic [31:0] q_q;       // dividend bits shift out, quotient bits shift in
  logic [31:0] r_q;       // working remainder; always < divisor, so 32 bits suffice
  logic [4:0]  cnt_q;     // iteration counter
  logic        busy_q;
  logic [31:0] quot_q;
  logic [31:0] rem_q;
  logic        dbz_q;

  logic [32:0] t_d;       // shifted partial remainder
  logic [32:0] diff_d;    // t - d; bit 32 is the borrow
  logic        ge_d;
  logic [31:0] r_d;
  logic [31:0] q_d;

  // One restoring step. The 33-bit subtract keeps r[31] from overflowing.
  always_comb begin
    t_d    = {r_q, q_q[31]};
    diff_d = t_d - {1'b0, d_q};
    ge_d   = ~diff_d[32];
    r_d    = ge_d ? diff_d[31:0] : t_d[31:0];
    q_d    = {q_q[30:0], ge_d};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            d_q     <= b;
            q_q     <= a;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          // Final iteration: publish this step's results directly.
          if (cnt_q == 5'd31) begin
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= (d_q == 32'd0);
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32x32.sv
// -----------------------------------------------------------------------------
// tb_div32x32 -- self-checking bench for div32x32.
// Expected results are queued when a division is started and popped when the
// divider drops busy; latency and held-zero outputs are checked alongside.
// -----------------------------------------------------------------------------
module tb_div32x32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   passed;
  int   total;

  div32x32 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    if (bv == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = av;
      e.dz = 1'b1;
    end else begin
      e.q  = av / bv;
      e.r  = av % bv;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Pulse start for one cycle; returns half a cycle after the accepting edge.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input bit push);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    if (push) sb.push_back(model(av, bv));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles (the first was already seen), optionally inject an
  // ignored start at busy cycle inj, then compare against the scoreboard.
  task automatic wait_done(input string tag, input int inj);
    int   cnt;
    bit   nz;
    exp_t e;
    cnt = 1;
    nz  = (quotient !== 32'd0) || (remainder !== 32'd0) || (div_by_zero !== 1'b0);
    while (cnt < 100) begin
      @(negedge clk);
      if (inj >= 0 && cnt == inj + 1) begin
        start = 1'b0;
        a = 32'd0;
        b = 32'd0;
      end
      if (busy !== 1'b1) break;
      if (quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) nz = 1'b1;
      cnt++;
      if (inj >= 0 && cnt == inj) begin
        start = 1'b1;
        a = 32'd7;
        b = 32'd2;
      end
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd32);
    chk({tag, "_zero_while_busy"}, 32'(nz), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quotient"}, quotient, e.q);
      chk({tag, "_remainder"}, remainder, e.r);
      chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    // Basic 100/7, also check the first busy cycle
    launch(32'd100, 32'd7, 1'b1);
    chk("basic_busy_after_accept", 32'(busy), 32'd1);
    wait_done("basic", -1);
    chk("basic_q_const", quotient, 32'd14);
    chk("basic_r_const", remainder, 32'd2);

    // Width boundaries
    launch(32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_done("max_by_1", -1);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("max_by_max", -1);
    launch(32'h8000_0000, 32'h8000_0001, 1'b1);
    wait_done("msb_lt", -1);
    chk("msb_lt_r_const", remainder, 32'h8000_0000);

    // Divide by zero, then a normal division clears the flag
    launch(32'd5, 32'd0, 1'b1);
    wait_done("div0", -1);
    chk("div0_q_const", quotient, 32'hFFFF_FFFF);
    chk("div0_flag_const", 32'(div_by_zero), 32'd1);
    launch(32'd9, 32'd3, 1'b1);
    chk("after_div0_flag_cleared", 32'(div_by_zero), 32'd0);
    wait_done("after_div0", -1);

    // start and operand changes during busy are ignored
    launch(32'd1000, 32'd10, 1'b1);
    wait_done("ignore_start", 10);
    chk("ignore_q_const", quotient, 32'd100);

    // Asynchronous reset mid-operation discards the division
    launch(32'd50, 32'd6, 1'b0);
    repeat (14) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_quotient", quotient, 32'd0);
    chk("async_rst_remainder", remainder, 32'd0);
    chk("async_rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    launch(32'd50, 32'd6, 1'b1);
    wait_done("post_reset", -1);
    chk("post_reset_q_const", quotient, 32'd8);

    // Back-to-back with start held high
    @(negedge clk);
    a = 32'd20;
    b = 32'd3;
    start = 1'b1;
    sb.push_back(model(32'd20, 32'd3));
    @(negedge clk);
    a = 32'd21;
    b = 32'd4;
    sb.push_back(model(32'd21, 32'd4));
    wait_done("b2b_first", -1);
    chk("b2b_first_q_const", quotient, 32'd6);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    chk("b2b_cleared_q", quotient, 32'd0);
    wait_done("b2b_second", -1);
    chk("b2b_second_r_const", remainder, 32'd1);

    // Random pairs against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      case (i % 4)
        0: rb = 32'($urandom_range(1, 255));
        1: rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      launch(ra, rb, 1'b1);
      wait_done("rand", -1);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
